// File: rtl/dmem_resp_mem.sv
// Data-memory responder for the dmem bus: serves word-addressed loads and
// stores with programmable wait states, byte-lane write enables and an
// out-of-range error flag that travels with the completion pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; Data_req is sampled and captured
// WAIT  | latency down-counter running toward the completion cycle
// DONE  | one-cycle completion: complete_data=1, dout/err just updated
module dmem_resp_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Data_req,
    input  logic              Data_rd,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    input  logic [BE_W-1:0]   Data_be,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    output logic              Data_err,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The counter only ever holds LAT-1 down to 1.
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0]  RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  WR_LOAD = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    // One extra bit so DEPTH == 2**ADDR_W is representable; the range
    // check uses every address bit, so high addresses never alias.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  lat_load;
    logic              enter_done;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] merged;
    logic              wr_en;

    // Request capture, latency down-counter and state sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        din_d      = din_q;
        be_d       = be_q;
        enter_done = 1'b0;
        lat_load   = Data_rd ? RD_LOAD : WR_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (Data_req) begin
                    rd_d   = Data_rd;
                    addr_d = Data_addr;
                    din_d  = Data_din;
                    be_d   = Data_be;
                    cnt_d  = lat_load;
                    if (lat_load == '0) begin
                        state_d    = ST_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory access for the completing request. The *_d fields hold the
    // live bus inputs on a zero-wait acceptance and the captured copy
    // otherwise, so one path serves both cases.
    always_comb begin
        in_range = ({1'b0, addr_d} < DEPTH_C);
        idx      = addr_d[IDX_W-1:0];
        cur_word = in_range ? mem_q[idx] : '0;
        merged   = cur_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be_d[i]) begin
                merged[8*i +: 8] = din_d[8*i +: 8];
            end
        end
        wr_en  = enter_done && !rd_d && in_range;
        dout_d = dout_q;
        err_d  = err_q;
        if (enter_done) begin
            err_d = !in_range;
            if (rd_d) begin
                dout_d = cur_word;
            end
        end
    end

    // Control and output registers; reset aborts any in-flight request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            be_q    <= be_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Storage array: cleared by reset, written on entry to DONE so the
    // new contents are already visible during the completion cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= merged;
        end
    end

    assign complete_data = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign Data_dout     = dout_q;
    assign Data_err      = err_q;

endmodule

// File: doc/dmem_resp_mem.md
Name: dmem_resp_mem

Overview:
Parametrised data-memory responder with a request/complete handshake and programmable wait-state latency. It sits on the processor's dmem bus in place of a zero-wait memory model and serves loads and stores. It adds byte-lane write enables and out-of-range error reporting. It is the generalised successor of the fixed 16-bit dmem bus, parametrised in data width, address width and depth.

Parameters:
DATA_W, 16, data bus width in bits; must be a multiple of 8.
ADDR_W, 16, address bus width in bits; word-addressed.
DEPTH, 256, number of DATA_W-bit words; must satisfy DEPTH <= 2**ADDR_W.
RD_LAT, 2, cycles from read acceptance to complete_data; must be >= 1.
WR_LAT, 1, cycles from write acceptance to complete_data; must be >= 1.
BE_W, DATA_W/8, number of byte enables (derived; do not override).

Ports:
clock  input  1  single clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
Data_req  input  1  request valid; sampled only in IDLE.
Data_rd  input  1  1 = read, 0 = write; qualified by Data_req.
Data_addr  input  ADDR_W  word address.
Data_din  input  DATA_W  write data.
Data_be  input  BE_W  byte-lane write enables; ignored on reads.
Data_dout  output  DATA_W  read data; valid when complete_data=1, held afterwards.
complete_data  output  1  one-cycle completion pulse.
Data_err  output  1  out-of-range flag; valid with complete_data, held afterwards.
busy  output  1  1 while a request is outstanding (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - complete_data=0, Data_err=0, Data_dout=0, busy=0.
  - All DEPTH words are cleared to 0.
  - An in-flight request is aborted: no write, no completion.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Data_req=1 accepts the request on that edge and captures rd, addr, din and be.
  - The latency counter loads LAT-1, where LAT = RD_LAT for reads and WR_LAT for writes.
  - Next state is DONE if LAT=1, otherwise WAIT.
- WAIT: the counter decrements each cycle; when it reaches 1, next state is DONE.
- DONE (exactly one cycle):
  - complete_data=1.
  - Write data is committed to memory on this edge.
  - Data_dout and Data_err are registered outputs updated coincident with complete_data.
  - Next state is always IDLE.
- Latency: request sampled at edge T gives complete_data high in cycle T+LAT.
- Minimum request spacing is LAT+1 cycles. Data_req is ignored (dropped, not queued) while busy=1, including in the DONE cycle.
- Reads:
  - Data_dout = mem[addr], using the value as of the DONE cycle. A write completing earlier is visible.
  - Data_dout holds its value until the next completion.
- Writes:
  - For each lane i with be[i]=1, byte i of mem[addr] takes byte i of din. Lanes with be[i]=0 are unchanged.
  - be all zero still completes normally with Data_err=0 and no change to memory.
  - Data_dout is unchanged on a write.
- Out of range (addr >= DEPTH):
  - The request still completes after LAT with Data_err=1.
  - A write has no effect on memory.
  - A read returns Data_dout=0.
  - Data_err is cleared by the next in-range completion.
- Simultaneous Data_req and reset deassertion in the same cycle: the request is not accepted. The first acceptance is on the edge after reset is high.
- Address index uses the full ADDR_W bits for the range check. There is no wrap-around or aliasing.

Test Plan:
- Reset check: assert reset=0 mid-WAIT of a write to addr 5 → complete_data never pulses, busy=0, Data_dout=0. After release, a read of addr 5 returns 0x0000.
- Read latency: RD_LAT=3; write 0xBEEF to addr 0x10, then read addr 0x10 with Data_req at edge T → complete_data=1 only in cycle T+3, Data_dout=0xBEEF held after the pulse, busy high for cycles T+1..T+3.
- Byte enables: write 0x1234 to addr 2 with be=2'b11, then write 0xABCD with be=2'b10 → a read of addr 2 returns 0xAB34. A write with be=2'b00 leaves it at 0xAB34.
- Out of range: DEPTH=256; write 0xFFFF to addr 0x0100 → complete_data with Data_err=1. A read of addr 0x0100 gives Data_err=1, Data_dout=0x0000. A following read of addr 0x00FF gives Data_err=0.
- Back-to-back and drop: hold Data_req=1 continuously with WR_LAT=1 → writes accepted every 2 cycles. A request presented in the DONE cycle is ignored, and the write count equals the number of complete_data pulses.
- Zero-wait boundary: RD_LAT=WR_LAT=1 → FSM goes IDLE→DONE→IDLE, and complete_data pulses in the cycle directly after acceptance.
